// File: rtl/fft4_pkg.sv
// fft4_pkg: shared FFT4 constants, state encoding and the fixed 4-point twiddle table.
package fft4_pkg;
  localparam int TWIDDLE_ONE = 65535;
  localparam int BINS = 4;
  typedef enum logic [1:0] {ST_COLLECT, ST_COMPUTE, ST_EMIT} state_t;
  // Twiddles are {+1, 0, -1} scaled by TWIDDLE_ONE; imaginary sign gives Im1 = x1 - x3
  function automatic int tw_re(int k, int n);
    return (k * n) % 4 == 0 ? 1 : (k * n) % 4 == 2 ? -1 : 0;
  endfunction
  function automatic int tw_im(int k, int n);
    return (k * n) % 4 == 1 ? 1 : (k * n) % 4 == 3 ? -1 : 0;
  endfunction
endpackage

// File: rtl/fft4_frame_ctrl_if.sv
// fft4_frame_ctrl_if: sample-in / bin-out stream bundle for fft4_frame_ctrl.
// Peak outputs exist only with FFT4_FRAME_CTRL_PEAK_EN defined.
interface fft4_frame_ctrl_if #(
  parameter int PRE = 16
);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic signed [PRE:0] in_data;
  logic out_valid;
  logic out_ready;
  logic signed [2*PRE:0] out_re;
  logic signed [2*PRE:0] out_im;
  logic [1:0] out_bin;
  logic out_last;
`ifdef FFT4_FRAME_CTRL_PEAK_EN
  logic [1:0] peak_bin;
  logic peak_valid;
`endif
  modport master (
    input flush, in_valid, in_data, out_ready,
`ifdef FFT4_FRAME_CTRL_PEAK_EN
    output peak_bin, peak_valid,
`endif
    output in_ready, out_valid, out_re, out_im, out_bin, out_last
  );
  modport slave (
    output flush, in_valid, in_data, out_ready,
`ifdef FFT4_FRAME_CTRL_PEAK_EN
    input peak_bin, peak_valid,
`endif
    input in_ready, out_valid, out_re, out_im, out_bin, out_last
  );
endinterface

// File: rtl/fft4_frame_ctrl_dp.sv
// fft4_frame_ctrl_dp: combinational 4-point DFT, Y[k] = sum X[n]*W(k,n)*TWIDDLE_ONE.
module fft4_frame_ctrl_dp
  import fft4_pkg::*;
#(
  parameter int PRE = 16
) (
  input  logic signed [PRE:0]   x  [BINS],
  output logic signed [2*PRE:0] re [BINS],
  output logic signed [2*PRE:0] im [BINS]
);
  always_comb begin
    re = '{default: '0};
    im = '{default: '0};
    for (int k = 0; k < BINS; k++)
      for (int n = 0; n < BINS; n++) begin
        re[k] = re[k] + (2*PRE+1)'(x[n]) * (2*PRE+1)'(tw_re(k, n) * TWIDDLE_ONE);
        im[k] = im[k] + (2*PRE+1)'(x[n]) * (2*PRE+1)'(tw_im(k, n) * TWIDDLE_ONE);
      end
  end
endmodule

// File: rtl/fft4_frame_ctrl.sv
// fft4_frame_ctrl: collects 4 samples, computes their 4-point DFT, streams bins 0..3.
// Define FFT4_FRAME_CTRL_PEAK_EN to add the peak_bin/peak_valid detector.
module fft4_frame_ctrl
  import fft4_pkg::*;
#(
  parameter int PRE = 16
) (
  input logic clk,
  input logic rst_n,
  fft4_frame_ctrl_if.master bus
);
  localparam logic [1:0] COLLECT = ST_COLLECT;
  localparam logic [1:0] COMPUTE = ST_COMPUTE;
  localparam logic [1:0] EMIT = ST_EMIT;
  logic [1:0] state, slot, bin;
  logic signed [PRE:0] x [BINS];
  logic signed [2*PRE:0] y_re [BINS], y_im [BINS], r_re [BINS], r_im [BINS];
  logic take, give;
  assign bus.in_ready = state == COLLECT;
  assign bus.out_valid = state == EMIT;
  assign bus.out_last = bus.out_valid && bin == 2'd3;
  assign bus.out_re = r_re[bin];
  assign bus.out_im = r_im[bin];
  assign bus.out_bin = bin;
  assign take = bus.in_valid && bus.in_ready;
  assign give = bus.out_valid && bus.out_ready;
  fft4_frame_ctrl_dp #(.PRE(PRE)) u_dp (.x(x), .re(y_re), .im(y_im));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || bus.flush) begin
      state <= COLLECT;
      slot <= '0;
      bin <= '0;
      x <= '{default: '0};
      r_re <= '{default: '0};
      r_im <= '{default: '0};
    end else begin
      if (take) begin
        x[slot] <= bus.in_data;
        slot <= slot + 2'd1;
        if (slot == 2'd3) state <= COMPUTE;
      end
      if (state == COMPUTE) begin
        r_re <= y_re;
        r_im <= y_im;
        state <= EMIT;
      end
      if (give) begin
        bin <= bin + 2'd1;
        if (bin == 2'd3) state <= COLLECT;
      end
    end
`ifdef FFT4_FRAME_CTRL_PEAK_EN
  function automatic logic [2*PRE+2:0] mag(logic signed [2*PRE:0] a, logic signed [2*PRE:0] b);
    logic signed [2*PRE+1:0] ea, eb;
    ea = (2*PRE+2)'(a);
    eb = (2*PRE+2)'(b);
    return (2*PRE+3)'(ea < 0 ? -ea : ea) + (2*PRE+3)'(eb < 0 ? -eb : eb);
  endfunction
  logic [2*PRE+2:0] m1, m2, m3, m12;
  logic [1:0] pk, peak_bin;
  logic peak_valid;
  // Strict compares keep the lowest index on ties
  always_comb begin
    m1 = mag(y_re[1], y_im[1]);
    m2 = mag(y_re[2], y_im[2]);
    m3 = mag(y_re[3], y_im[3]);
    m12 = m2 > m1 ? m2 : m1;
    pk = m3 > m12 ? 2'd3 : m2 > m1 ? 2'd2 : 2'd1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      peak_bin <= '0;
      peak_valid <= 1'b0;
    end else begin
      peak_valid <= !bus.flush && state == COMPUTE;
      if (!bus.flush && state == COMPUTE) peak_bin <= pk;
    end
  assign bus.peak_bin = peak_bin;
  assign bus.peak_valid = peak_valid;
`endif
endmodule

// File: tb/tb_fft4_frame_ctrl.sv
// tb_fft4_frame_ctrl: table-driven frames with a bin scoreboard plus corner-case sequences.
module tb_fft4_frame_ctrl;
  import fft4_pkg::*;
  localparam int PRE = 16;
  typedef struct {
    int s [4];
    longint re [4];
    longint im [4];
    int pk;
  } vec_t;
  typedef struct {
    logic signed [63:0] re;
    logic signed [63:0] im;
    logic [1:0] bin;
    logic last;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t q [$];
  exp_t e_m;
  vec_t tab [5];
  always #5 clk = ~clk;
  fft4_frame_ctrl_if #(.PRE(PRE)) bus ();
  fft4_frame_ctrl #(.PRE(PRE)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", nm);
  endtask

  always @(negedge clk)
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bin: got bin %0d, expected none", bus.out_bin);
      end else begin
        e_m = q.pop_front();
        chk("bin_re", bus.out_re, e_m.re);
        chk("bin_im", bus.out_im, e_m.im);
        chk("bin_idx", 64'(bus.out_bin), 64'(e_m.bin));
        chk("bin_last", 64'(bus.out_last), 64'(e_m.last));
      end
    end

  task automatic put(input int v);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = (PRE+1)'(v);
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) fail("put_ready");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic frame(input int i);
    for (int n = 0; n < 4; n++) put(tab[i].s[n]);
    for (int k = 0; k < 4; k++) q.push_back('{tab[i].re[k], tab[i].im[k], 2'(k), k == 3});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      n++;
      step();
    end
    if (!bus.out_valid) fail("wait_valid");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || !bus.in_ready) && n < 200) begin
      n++;
      step();
    end
    if (q.size() != 0 || !bus.in_ready) fail("drain");
  endtask

  initial begin
    tab[0] = '{s: '{1, 2, 3, 4}, re: '{655350, -131070, -131070, -131070}, im: '{0, -131070, 0, 131070}, pk: 1};
    tab[1] = '{s: '{5, 5, 5, 5}, re: '{1310700, 0, 0, 0}, im: '{0, 0, 0, 0}, pk: 1};
    tab[2] = '{s: '{1, 1, 1, 1}, re: '{262140, 0, 0, 0}, im: '{0, 0, 0, 0}, pk: 1};
    tab[3] = '{s: '{1, -1, 1, -1}, re: '{0, 0, 262140, 0}, im: '{0, 0, 0, 0}, pk: 2};
    tab[4] = '{s: '{3, 0, -2, 7}, re: '{524280, 327675, -393210, 327675}, im: '{0, -458745, 0, 458745}, pk: 1};
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_out_last", 64'(bus.out_last), 0);
    chk("rst_out_re", bus.out_re, 0);
    chk("rst_out_im", bus.out_im, 0);
    chk("rst_out_bin", 64'(bus.out_bin), 0);
`ifdef FFT4_FRAME_CTRL_PEAK_EN
    chk("rst_peak_valid", 64'(bus.peak_valid), 0);
    chk("rst_peak_bin", 64'(bus.peak_bin), 0);
`endif
    step();
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 64'(bus.in_ready), 1);

    for (int i = 0; i < 5; i++) begin
      frame(i);
      chk("lat_compute", 64'(bus.out_valid), 0);
      chk("lat_in_ready", 64'(bus.in_ready), 0);
      step();
      chk("lat_emit", 64'(bus.out_valid), 1);
`ifdef FFT4_FRAME_CTRL_PEAK_EN
      chk("peak_valid_on", 64'(bus.peak_valid), 1);
      chk("peak_bin", 64'(bus.peak_bin), 64'(tab[i].pk));
      step();
      chk("peak_valid_off", 64'(bus.peak_valid), 0);
`endif
      drain();
    end

    // backpressure at bin 1
    bus.out_ready = 1'b0;
    frame(0);
    wait_valid();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("hold_bin", 64'(bus.out_bin), 1);
      chk("hold_re", bus.out_re, -131070);
      chk("hold_im", bus.out_im, -131070);
      chk("hold_valid", 64'(bus.out_valid), 1);
      chk("hold_in_ready", 64'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    drain();

    // flush after two samples
    put(9);
    put(-7);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_in_ready", 64'(bus.in_ready), 1);
    chk("flush_out_valid", 64'(bus.out_valid), 0);
    frame(1);
    drain();

    // flush during EMIT
    bus.out_ready = 1'b0;
    frame(3);
    wait_valid();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    q.delete();
    chk("flush_emit_valid", 64'(bus.out_valid), 0);
    chk("flush_emit_ready", 64'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    frame(4);
    drain();

    // async reset during EMIT at bin 2
    bus.out_ready = 1'b0;
    frame(0);
    wait_valid();
    bus.out_ready = 1'b1;
    step();
    step();
    bus.out_ready = 1'b0;
    chk("rst_emit_bin", 64'(bus.out_bin), 2);
    rst_n = 1'b0;
    #1;
    chk("rst_emit_valid", 64'(bus.out_valid), 0);
    chk("rst_emit_idx", 64'(bus.out_bin), 0);
    q.delete();
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    frame(2);
    drain();

    // in_valid held through COMPUTE/EMIT
    bus.out_ready = 1'b0;
    frame(4);
    bus.in_valid = 1'b1;
    bus.in_data = (PRE+1)'(99);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("busy_in_ready", 64'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    frame(3);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/fft4_frame_ctrl.md
FFT4_FRAME_CTRL -- requirements
Module: fft4_frame_ctrl

Interface
REQ-001 SHALL have parameter PRE, default 16, giving sample precision; samples are PRE+1 bits signed and results are 2*PRE+1 bits signed.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port flush, input, 1 bit: synchronous frame abort.
REQ-005 SHALL have port in_valid, input, 1 bit: input sample valid.
REQ-006 SHALL have port in_ready, output, 1 bit: controller accepts a sample.
REQ-007 SHALL have port in_data, input, PRE+1 bits: signed time-domain sample.
REQ-008 SHALL have port out_valid, output, 1 bit: output bin valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts a bin.
REQ-010 SHALL have port out_re, output, 2*PRE+1 bits: signed real part of the bin.
REQ-011 SHALL have port out_im, output, 2*PRE+1 bits: signed imaginary part of the bin.
REQ-012 SHALL have port out_bin, output, 2 bits: bin index k.
REQ-013 SHALL have port out_last, output, 1 bit: asserted with bin 3.

Function
REQ-014 SHALL implement states COLLECT, COMPUTE and EMIT.
REQ-015 SHALL assert in_ready only in COLLECT.
REQ-016 SHALL store the sample in slot n on each in_valid&&in_ready handshake, with n counting 0..3.
REQ-017 SHALL move from COLLECT to COMPUTE on the handshake that fills slot 3.
REQ-018 SHALL stay in COMPUTE exactly one cycle, register all four Re/Im results from the 4-point DFT datapath, then enter EMIT.
REQ-019 SHALL use datapath coefficients of exactly +65535, 0 or -65535: Y[k] = sum over n of X[n]*W(k,n) * 65535, using the fixed 4-point twiddle table.
REQ-020 SHALL, in EMIT, hold out_valid high and present bins k=0,1,2,3 in order, advancing k only on an out_valid&&out_ready handshake.
REQ-021 SHALL hold out_re/out_im/out_bin stable while out_valid is high and out_ready is low.
REQ-022 SHALL return to COLLECT with slot count 0 on the bin-3 handshake; frames SHALL NOT overlap.
REQ-023 SHALL give a latency of 2 cycles from the slot-3 handshake edge to out_valid high.
REQ-024 SHALL ignore in_valid outside COLLECT, consuming no data.
REQ-025 SHALL, on flush high, force COLLECT with slot count 0 and out_valid low on the next edge, discarding all stored samples and results.
REQ-026 SHALL give flush priority over any handshake in the same cycle.
REQ-027 SHALL let out_re, out_im and out_bin be don't-care while out_valid is low.

Reset
REQ-028 SHALL, while rst_n is low, immediately force state COLLECT, slot count 0, bin index 0, in_ready=1 after release, out_valid=0, out_last=0, out_re=0, out_im=0 and out_bin=0.
REQ-029 SHALL, when reset is asserted mid-frame, lose the partial frame and emit no bins for it.

Configuration
REQ-030 SHALL, with macro FFT4_FRAME_CTRL_PEAK_EN defined, add outputs peak_bin (2 bits) and peak_valid (1 bit).
REQ-031 SHALL compute peak_bin during COMPUTE as the argmax of |Re|+|Im| over bins 1..3, choosing the lowest index on a tie.
REQ-032 SHALL pulse peak_valid high for one cycle on entry to EMIT.
REQ-033 SHALL reset peak_bin and peak_valid to 0.
REQ-034 SHALL, without the macro, omit those ports and the magnitude logic entirely, leaving all other behaviour identical.

Structure
REQ-035 SHALL place the state enum, the constant TWIDDLE_ONE=65535 and the bin-count constant 4 in shared package fft4_pkg.
REQ-036 SHALL instantiate the existing combinational 4-point FFT datapath as its single sub-module, fed from the four sample slots.

Verification
REQ-037 SHALL cover: samples 1,2,3,4 with out_ready=1 -> bins (Re,Im) = (655350,0), (-131070,-131070), (-131070,0), (-131070,131070); out_last with bin 3; out_valid 2 cycles after the 4th handshake.
REQ-038 SHALL cover: out_ready held 0 for 5 cycles at bin 1 -> bin 1 held stable with in_ready=0; resumes with bin 2 after release.
REQ-039 SHALL cover: flush asserted after 2 samples, then samples 5,5,5,5 -> output bin 0 = (1310700,0) and bins 1..3 all zero.
REQ-040 SHALL cover: rst_n pulsed low during EMIT at bin 2 -> out_valid drops immediately, and the next frame of four 1s yields bin 0 = 262140.
REQ-041 SHALL cover: in_valid held high during COMPUTE/EMIT -> no sample consumed, and the next frame equals exactly the next 4 accepted samples.
REQ-042 SHALL cover: PEAK_EN with samples 1,2,3,4 -> peak_bin=1 (tie between bins 1 and 3) with peak_valid pulsing once; samples 1,-1,1,-1 -> peak_bin=2.
